// File: rtl/hdmi_pixel_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_pixel_feeder_if
// Description : Bundle of the upstream pixel stream, the timing-engine
//               request side and the feeder status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface hdmi_pixel_feeder_if;
    logic [15:0] s_data;
    logic        s_sof;
    logic        s_valid;
    logic        s_ready;
    logic        video_vs;
    logic        data_req;
    logic [15:0] pixel_data;
    logic        frame_locked;
    logic [15:0] underflow_cnt;

    // Environment side: drives pixels, sync and requests
    modport master (
        output s_data, s_sof, s_valid, video_vs, data_req,
        input  s_ready, pixel_data, frame_locked, underflow_cnt
    );

    // Feeder side
    modport slave (
        input  s_data, s_sof, s_valid, video_vs, data_req,
        output s_ready, pixel_data, frame_locked, underflow_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hdmi_pixel_feeder.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_pixel_feeder
// Description : Frame-aligned RGB565 pixel source. Buffers the upstream
//               stream in a first-word-fall-through FIFO, re-locks to the
//               start of frame on every vertical sync edge and answers one
//               pixel per data_req with a registered output.
// Revision    : 1.0 - initial release
// ============================================================================
module hdmi_pixel_feeder #(
    parameter int          DEPTH      = 1024,
    parameter logic [15:0] FILL_COLOR = 16'h0000,
    parameter bit          VS_POL     = 1'b1
) (
    input  wire logic             pixel_clk_i,
    input  wire logic             sys_rst_n_i,
    hdmi_pixel_feeder_if.slave    bus
);

    localparam int             AW     = $clog2(DEPTH);
    localparam int             CW     = AW + 1;
    localparam logic [CW-1:0]  C_FULL = CW'(DEPTH);

    localparam logic [2:0] S_SYNC   = 3'd0;
    localparam logic [2:0] S_ALIGN  = 3'd1;
    localparam logic [2:0] S_ARMED  = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [16:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic           rst_done_q;

    logic           vs_sync_q, vs_prev_q;
    logic           vs_edge;

    logic [2:0]     state_q, state_d;

    logic [15:0]    pixel_data_q, pixel_data_d;
    logic           frame_locked_q;
    logic [15:0]    underflow_cnt_q, underflow_cnt_d;

    logic           fifo_push, fifo_pop, fifo_empty;
    logic [15:0]    head_data;
    logic           head_sof;
    logic           serve, discard, underflow;

    // ------------------------------------------------------------------
    // FIFO status and handshake
    // ------------------------------------------------------------------
    // Ready comes only from the registered count, so a pop never frees a
    // slot for a push in the same cycle.
    assign bus.s_ready = rst_done_q && (count_q != C_FULL);
    assign fifo_push   = bus.s_valid && bus.s_ready;
    assign fifo_empty  = (count_q == '0);
    assign head_data   = mem[rd_ptr_q][15:0];
    assign head_sof    = mem[rd_ptr_q][16];

    // Holds s_ready low for the first cycle after reset release
    always_ff @(posedge pixel_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) rst_done_q <= 1'b0;
        else              rst_done_q <= 1'b1;
    end

    // Storage array, written on every accepted push
    always_ff @(posedge pixel_clk_i) begin
        if (fifo_push) mem[wr_ptr_q] <= {bus.s_sof, bus.s_data};
    end

    // Occupancy next value; push and pop together cancel out
    always_comb begin
        count_d = count_q;
        case ({fifo_push, fifo_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers and occupancy
    always_ff @(posedge pixel_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (fifo_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (fifo_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Vertical sync edge detection
    // ------------------------------------------------------------------
    // Both stages start at the active level so a sync already active at
    // reset release is not mistaken for a fresh edge.
    always_ff @(posedge pixel_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            vs_sync_q <= VS_POL;
            vs_prev_q <= VS_POL;
        end else begin
            vs_sync_q <= bus.video_vs;
            vs_prev_q <= vs_sync_q;
        end
    end

    assign vs_edge = (vs_sync_q == VS_POL) && (vs_prev_q != VS_POL);

    // ------------------------------------------------------------------
    // Frame-lock state machine
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge pixel_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) state_q <= S_SYNC;
        else              state_q <= state_d;
    end

    // Next-state decode; a request in the same cycle as a sync edge is
    // served first, the edge only steers where the state goes next.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_SYNC:   if (vs_edge) state_d = S_ALIGN;
            S_ALIGN:  if (!fifo_empty && head_sof) state_d = S_ARMED;
            S_ARMED:  if (bus.data_req && !fifo_empty) state_d = S_STREAM;
            S_STREAM: begin
                if (bus.data_req && fifo_empty)    state_d = S_SYNC;
                else if (bus.data_req && head_sof) state_d = vs_edge ? S_ARMED : S_HOLD;
                else if (vs_edge)                  state_d = S_ALIGN;
            end
            S_HOLD:   if (vs_edge) state_d = S_ARMED;
            default:  state_d = S_SYNC;
        endcase
    end

    // Output decode: pops, served pixel and underflow counter update
    always_comb begin
        serve     = bus.data_req && !fifo_empty &&
                    ((state_q == S_ARMED) || ((state_q == S_STREAM) && !head_sof));
        discard   = (state_q == S_ALIGN) && !fifo_empty && !head_sof;
        underflow = (state_q == S_STREAM) && bus.data_req && fifo_empty;
        fifo_pop  = serve || discard;

        pixel_data_d = pixel_data_q;
        if (bus.data_req) pixel_data_d = serve ? head_data : FILL_COLOR;

        underflow_cnt_d = underflow_cnt_q;
        if (underflow && (underflow_cnt_q != 16'hFFFF))
            underflow_cnt_d = underflow_cnt_q + 16'd1;
    end

    // Registered outputs; lock flag tracks the state being entered
    always_ff @(posedge pixel_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            pixel_data_q    <= 16'h0000;
            frame_locked_q  <= 1'b0;
            underflow_cnt_q <= 16'h0000;
        end else begin
            pixel_data_q    <= pixel_data_d;
            frame_locked_q  <= (state_d == S_ARMED) || (state_d == S_STREAM);
            underflow_cnt_q <= underflow_cnt_d;
        end
    end

    assign bus.pixel_data    = pixel_data_q;
    assign bus.frame_locked  = frame_locked_q;
    assign bus.underflow_cnt = underflow_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_pixel_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdmi_pixel_feeder
// Description : Directed scoreboard bench for hdmi_pixel_feeder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdmi_pixel_feeder;

    localparam int          DEPTH = 32;
    localparam logic [15:0] FILL  = 16'hABCD;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] exp_q [$];

    hdmi_pixel_feeder_if bus();

    hdmi_pixel_feeder #(
        .DEPTH      (DEPTH),
        .FILL_COLOR (FILL),
        .VS_POL     (1'b1)
    ) dut (
        .pixel_clk_i (clk),
        .sys_rst_n_i (rst_n),
        .bus         (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    // Direct status comparison
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every request sampled on a rising edge is answered on the
    // following falling edge with the next queued expected pixel.
    initial begin
        logic        r;
        logic [15:0] e;
        forever begin
            @(posedge clk);
            r = bus.data_req && rst_n;
            @(negedge clk);
            if (r) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pixel_data: got %h with no expected value queued", bus.pixel_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.pixel_data !== e) begin
                        errors++;
                        $display("FAIL pixel_data: got %h expected %h", bus.pixel_data, e);
                    end
                end
            end
        end
    end

    task automatic push(input logic [15:0] d, input logic sof);
        int n;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_sof   = sof;
        n = 0;
        while (!bus.s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.s_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: s_ready got 0 expected 1 for data %h", d);
        end
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
    endtask

    // One request cycle; expected answer goes to the scoreboard
    task automatic req(input logic [15:0] exp);
        bus.data_req = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
    endtask

    task automatic req_end();
        bus.data_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic vs_pulse();
        bus.video_vs = 1'b1;
        repeat (4) @(negedge clk);
        bus.video_vs = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        rst_n        = 1'b1;
        bus.s_data   = '0;
        bus.s_sof    = 1'b0;
        bus.s_valid  = 1'b0;
        bus.video_vs = 1'b0;
        bus.data_req = 1'b0;
        #1 rst_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_pixel_data", bus.pixel_data, 16'h0000);
        check("reset_frame_locked", {15'd0, bus.frame_locked}, 16'd0);
        check("reset_underflow_cnt", bus.underflow_cnt, 16'h0000);
        check("reset_s_ready", {15'd0, bus.s_ready}, 16'd0);
        rst_n = 1'b1;
        check("release_s_ready_first_cycle", {15'd0, bus.s_ready}, 16'd0);
        @(negedge clk);
        check("release_s_ready_after", {15'd0, bus.s_ready}, 16'd1);

        // Normal frame
        for (int i = 1; i <= 16; i++) push(16'(i), i == 1);
        vs_pulse();
        check("normal_frame_locked", {15'd0, bus.frame_locked}, 16'd1);
        for (int i = 1; i <= 16; i++) req(16'(i));
        req_end();
        check("normal_underflow_cnt", bus.underflow_cnt, 16'h0000);
        check("normal_locked_stream", {15'd0, bus.frame_locked}, 16'd1);

        // Underflow
        for (int i = 0; i < 4; i++) push(16'h0021 + 16'(i), 1'b0);
        for (int i = 0; i < 4; i++) req(16'h0021 + 16'(i));
        req(FILL);
        req(FILL);
        req_end();
        check("underflow_cnt", bus.underflow_cnt, 16'h0001);
        check("underflow_frame_locked", {15'd0, bus.frame_locked}, 16'd0);
        req(FILL);
        req_end();

        // Misaligned start: 5 stray pixels, frame A (8), frame B (4)
        for (int i = 0; i < 5; i++) push(16'h0031 + 16'(i), 1'b0);
        for (int i = 0; i < 8; i++) push(16'h0041 + 16'(i), i == 0);
        for (int i = 0; i < 4; i++) push(16'h0051 + 16'(i), i == 0);
        bus.video_vs = 1'b1;
        repeat (7) @(negedge clk);
        check("misalign_not_locked_during_discard", {15'd0, bus.frame_locked}, 16'd0);
        @(negedge clk);
        check("misalign_locked_after_5_discards", {15'd0, bus.frame_locked}, 16'd1);
        bus.video_vs = 1'b0;
        repeat (2) @(negedge clk);

        // Short frame A then B
        for (int i = 0; i < 8; i++) req(16'h0041 + 16'(i));
        for (int i = 0; i < 4; i++) req(FILL);
        req_end();
        check("short_hold_unlocked", {15'd0, bus.frame_locked}, 16'd0);
        vs_pulse();
        check("short_relocked", {15'd0, bus.frame_locked}, 16'd1);
        for (int i = 0; i < 4; i++) req(16'h0051 + 16'(i));
        req_end();

        // Full / backpressure
        bus.s_valid = 1'b1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            bus.s_data = 16'h0100 + 16'(n);
            if (bus.s_ready) n++;
            @(negedge clk);
        end
        check("full_push_count", 16'(n), 16'(DEPTH));
        check("full_s_ready", {15'd0, bus.s_ready}, 16'd0);
        req(16'h0100);
        bus.data_req = 1'b0;
        check("full_after_pop_s_ready", {15'd0, bus.s_ready}, 16'd1);
        bus.s_data = 16'h01FF;
        @(negedge clk);
        bus.s_valid = 1'b0;
        check("full_refill_s_ready", {15'd0, bus.s_ready}, 16'd0);
        for (int i = 1; i < DEPTH; i++) req(16'h0100 + 16'(i));
        req(16'h01FF);
        req_end();

        // Mid-frame reset
        for (int i = 0; i < 4; i++) push(16'h0061 + 16'(i), 1'b0);
        req(16'h0061);
        req(16'h0062);
        req_end();
        rst_n = 1'b0;
        #1;
        check("midreset_pixel_data", bus.pixel_data, 16'h0000);
        check("midreset_frame_locked", {15'd0, bus.frame_locked}, 16'd0);
        check("midreset_s_ready", {15'd0, bus.s_ready}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset_release_s_ready", {15'd0, bus.s_ready}, 16'd0);
        @(negedge clk);
        check("midreset_s_ready_after", {15'd0, bus.s_ready}, 16'd1);
        check("midreset_underflow_cnt", bus.underflow_cnt, 16'h0000);
        for (int i = 0; i < 3; i++) push(16'h0071 + 16'(i), i == 0);
        vs_pulse();
        check("midreset_relock", {15'd0, bus.frame_locked}, 16'd1);
        for (int i = 0; i < 3; i++) req(16'h0071 + 16'(i));
        req_end();
        @(negedge clk);
        check("scoreboard_drained", 16'(exp_q.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
